program_loader: RTL
===================

# program_loader

Serial program loader for the calculator core. It accepts a framed byte stream over a valid/ready handshake and assembles it into 16-bit instruction words. It writes those words into instruction memory at addresses 0, 1, 2, … and holds the core in reset while loading is in progress. It is the writer side of the instruction-memory interface that the core's fetch path reads through its 10-bit PC address.

## Interface
- ADDR_W, 10, instruction memory address width (1024 words)
- DATA_W, 16, instruction word width
- MAX_WORDS, 1024, largest accepted frame length
- CLK  input  1  system clock, all state changes on rising edge
- RST  input  1  reset, asynchronous, active-low
- START  input  1  one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR
- BYTE_IN  input  8  incoming frame byte
- BYTE_VALID  input  1  BYTE_IN is valid
- BYTE_READY  output  1  loader accepts a byte this cycle
- IM_WE  output  1  instruction memory write strobe
- IM_ADDR  output  ADDR_W  write address
- IM_DATA  output  DATA_W  write data
- CORE_HOLD  output  1  keeps the core in reset while high
- BUSY  output  1  a load is in progress
- DONE  output  1  last load completed with a good checksum; sticky until next START
- ERROR  output  1  last load failed; sticky until next START

## Operation
- Frame format: LEN_H, LEN_L, then N words as two bytes each, high byte first, then CHK.
  - N = {LEN_H, LEN_L}.
  - CHK = XOR of all 2N data bytes. Length bytes are excluded.
- A byte transfers on a rising edge where BYTE_VALID and BYTE_READY are both high.
- FSM states:
  - IDLE: on START go to LEN_HI. Clear DONE, ERROR, the address counter and the checksum accumulator. Set CORE_HOLD and BUSY.
  - LEN_HI: on transfer, latch LEN_H and go to LEN_LO.
  - LEN_LO: on transfer, latch LEN_L. If N == 0 or N > MAX_WORDS, go to ERR. Otherwise go to DATA_HI.
  - DATA_HI: on transfer, latch the high byte, XOR it into the checksum, and go to DATA_LO.
  - DATA_LO: on transfer, latch the low byte, XOR it into the checksum, and go to WRITE.
  - WRITE: drive one cycle with IM_WE=1, IM_ADDR=addr, IM_DATA={hi,lo}. Then addr increments. If addr+1 == N go to CHECK, else go to DATA_HI.
  - CHECK: on transfer, compare BYTE_IN with the accumulator. On match go to DONE, on mismatch go to ERR.
  - DONE: DONE=1, CORE_HOLD=0, BUSY=0. START begins a new load.
  - ERR: ERROR=1, BUSY=0, CORE_HOLD stays 1 so a partial program never runs. START begins a new load.
- BYTE_READY is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- Address counter: ADDR_W+1 bits wide, compared against the 16-bit N. The maximum frame writes 0..1023. The address never wraps.
- START in any busy state (LEN_HI..CHECK) is ignored. The current frame continues.
- START in DONE or ERR behaves exactly as START in IDLE.

## Timing
- Reset (RST low, asynchronous) takes effect immediately and forces the following values:
  - state = IDLE
  - BYTE_READY = 0, IM_WE = 0, IM_ADDR = 0, IM_DATA = 0
  - CORE_HOLD = 0, BUSY = 0, DONE = 0, ERROR = 0
  - internal counters and the accumulator = 0
- Reset mid-frame aborts the load with no further writes. Words already written stay in memory.
- START sampled at edge k makes CORE_HOLD, BUSY and BYTE_READY high from cycle k+1.
- Throughput with BYTE_VALID held high:
  - the loader accepts one byte per cycle, except for the one WRITE bubble per word;
  - each word takes 3 cycles;
  - a full frame of N words takes 2 + 3N + 1 cycles from the first transfer to DONE/ERR.
- IM_WE is high for exactly one cycle per word. IM_ADDR and IM_DATA are stable in that cycle and hold their last values afterwards.
- DONE or ERROR goes high on the cycle after the CHK transfer (or after LEN_L for a length error). CORE_HOLD falls in the same cycle as DONE rises.
- BYTE_VALID may drop at any time. The FSM waits in its current state with no timeout.
- BYTE_IN is ignored when no transfer occurs.

## Test plan
- Reset then load N=2 with words 0x1234 and 0xABCD, CHK=0x12^0x34^0xAB^0xCD=0x40 -> IM_WE pulses twice (addr 0 data 0x1234, addr 1 data 0xABCD), DONE=1, ERROR=0, CORE_HOLD=0, total 9 cycles from the first transfer with VALID held high.
- Same frame with CHK=0x41 -> both words are written, ERROR=1, DONE=0, CORE_HOLD stays 1.
- Length 0x0000, then length 0x0401 -> ERROR=1 right after LEN_L, no IM_WE, BYTE_READY=0. A following START restarts and accepts a good frame.
- Length 0x0400 with incrementing words -> the last write is addr 1023, the address never wraps, DONE=1.
- Random BYTE_VALID gaps plus START pulses during DATA_HI and CHECK -> the written contents are identical to the gap-free case and the START pulses have no effect.
- RST low during DATA_LO of word 3 -> all outputs are at their reset values immediately, and no write to addr 3 occurs.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
// Serial program loader for the calculator core. It receives a framed byte
// stream (LEN_H, LEN_L, N words high byte first, XOR checksum) over a
// valid/ready handshake. It writes each assembled 16-bit word into
// instruction memory at consecutive addresses starting at 0, and holds the
// core in reset while a load is in progress.
// Ports:
//   CLK, RST           clock, asynchronous active-low reset
//   START              one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   BYTE_IN/BYTE_VALID incoming byte and its valid flag
//   BYTE_READY         loader can accept a byte this cycle
//   IM_WE/IM_ADDR/IM_DATA  instruction memory write port
//   CORE_HOLD          keeps the core in reset while high
//   BUSY               a load is in progress
//   DONE/ERROR         sticky result of the last load
module program_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        BYTE_IN,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic [DATA_W-1:0] IM_DATA,
  output logic              CORE_HOLD,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR
);

  localparam int LEN_W = 16;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_DATA_HI = 4'd3,
    S_DATA_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_CHECK   = 4'd6,
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          chk_q, chk_d;
  // One bit wider than the memory address so a full 1024-word frame never wraps.
  logic [ADDR_W:0]     addr_q, addr_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [DATA_W-1:0]   im_data_q, im_data_d;
  logic                hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer_s;
  logic [LEN_W-1:0]    n_s;
  logic [LEN_W-1:0]    addr_next_s;

  assign xfer_s      = BYTE_VALID & ready_q;
  assign n_s         = {len_q[15:8], BYTE_IN};
  assign addr_next_s = LEN_W'(addr_q) + 16'd1;

  // Next-state and next-output computation for the loader FSM.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hi_d      = hi_q;
    chk_d     = chk_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    im_addr_d = im_addr_q;
    im_data_d = im_data_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          addr_d  = '0;
          chk_d   = 8'h00;
          hold_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_HI: begin
        if (xfer_s) begin
          len_d[15:8] = BYTE_IN;
          state_d     = S_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_LO: begin
        if (xfer_s) begin
          len_d[7:0] = BYTE_IN;
          if ((n_s == 16'd0) || (n_s > LEN_W'(MAX_WORDS))) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DATA_HI;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DATA_HI: begin
        if (xfer_s) begin
          hi_d    = BYTE_IN;
          chk_d   = chk_q ^ BYTE_IN;
          state_d = S_DATA_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_DATA_LO: begin
        // The write port is loaded here so IM_WE/ADDR/DATA are all
        // registered and valid together during the WRITE cycle.
        if (xfer_s) begin
          chk_d     = chk_q ^ BYTE_IN;
          im_data_d = {hi_q, BYTE_IN};
          im_addr_d = addr_q[ADDR_W-1:0];
          we_d      = 1'b1;
          state_d   = S_WRITE;
        end else begin
          state_d = state_q;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (addr_next_s == len_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (xfer_s) begin
          busy_d = 1'b0;
          if (BYTE_IN == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: ready_d = 1'b1;
      default:                                          ready_d = 1'b0;
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      len_q     <= 16'd0;
      hi_q      <= 8'h00;
      chk_q     <= 8'h00;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      im_addr_q <= '0;
      im_data_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      chk_q     <= chk_d;
      addr_q    <= addr_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      im_addr_q <= im_addr_d;
      im_data_q <= im_data_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign BYTE_READY = ready_q;
  assign IM_WE      = we_q;
  assign IM_ADDR    = im_addr_q;
  assign IM_DATA    = im_data_q;
  assign CORE_HOLD  = hold_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERROR      = err_q;

endmodule
